// File: rtl/fd_pkg.sv
// Face-detection shared package: frame geometry, pixel layout,
// default skin thresholds and the classifier FSM state type.
package fd_pkg;

  localparam int FD_H_RES     = 160;
  localparam int FD_V_RES     = 120;
  localparam int FD_ADDR_W    = 15;
  localparam int FD_DATA_W    = 20;
  localparam int FD_RD_LAT    = 1;

  localparam int FD_CH_W      = 10;
  localparam int FD_CB_LSB    = 0;
  localparam int FD_CR_LSB    = 10;
  localparam int FD_CRD_W     = 8;

  localparam int FD_CB_MIN    = 308;
  localparam int FD_CB_MAX    = 508;
  localparam int FD_CR_MIN    = 532;
  localparam int FD_CR_MAX    = 692;
  localparam int FD_MIN_COUNT = 400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE,
    ST_WAIT_LOW
  } det_state_e;

  // Unsigned inclusive window test on one chroma channel.
  function automatic logic in_win(
    input logic [FD_CH_W-1:0] v,
    input int                 lo,
    input int                 hi
  );
    return (32'(v) >= 32'(lo)) && (32'(v) <= 32'(hi));
  endfunction

endpackage

// File: rtl/skin_pixel_classifier.sv
// Skin pixel classifier: Cb/Cr window test, one register stage,
// coordinates travel alongside the flag.
module skin_pixel_classifier
  import fd_pkg::*;
#(
  parameter int CB_MIN = FD_CB_MIN,
  parameter int CB_MAX = FD_CB_MAX,
  parameter int CR_MIN = FD_CR_MIN,
  parameter int CR_MAX = FD_CR_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [FD_CH_W-1:0]  cb,
  input  logic [FD_CH_W-1:0]  cr,
  input  logic [FD_CRD_W-1:0] in_x,
  input  logic [FD_CRD_W-1:0] in_y,
  output logic                out_skin,
  output logic [FD_CRD_W-1:0] out_x,
  output logic [FD_CRD_W-1:0] out_y
);

  logic hit;

  assign hit = in_win(cb, CB_MIN, CB_MAX) &&
               in_win(cr, CR_MIN, CR_MAX);

  // Register the skin flag together with its pixel coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_skin <= 1'b0;
      out_x    <= '0;
      out_y    <= '0;
    end else begin
      out_skin <= in_valid && hit;
      out_x    <= in_x;
      out_y    <= in_y;
    end
  end

endmodule

// File: rtl/skin_region_detector.sv
// Skin region detector: scans the frame BRAM, classifies pixels,
// accumulates skin count and bounding box, pulses detect_done.
module skin_region_detector
  import fd_pkg::*;
#(
  parameter int H_RES     = FD_H_RES,
  parameter int V_RES     = FD_V_RES,
  parameter int ADDR_W    = FD_ADDR_W,
  parameter int DATA_W    = FD_DATA_W,
  parameter int RD_LAT    = FD_RD_LAT,
  parameter int CB_MIN    = FD_CB_MIN,
  parameter int CB_MAX    = FD_CB_MAX,
  parameter int CR_MIN    = FD_CR_MIN,
  parameter int CR_MAX    = FD_CR_MAX,
  parameter int MIN_COUNT = FD_MIN_COUNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              detect_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              detect_done,
  output logic              face_found,
  output logic [ADDR_W-1:0] skin_count,
  output logic [7:0]        x_min,
  output logic [7:0]        x_max,
  output logic [7:0]        y_min,
  output logic [7:0]        y_max
);

  localparam int N = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(N - 1);
  localparam logic [7:0] X_LAST = 8'(H_RES - 1);

  det_state_e state, state_nx;

  logic       en_z;
  logic [1:0] drain_cnt;
  logic [7:0] x_cnt, y_cnt;
  logic       start;

  logic       tag_v [RD_LAT];
  logic [7:0] tag_x [RD_LAT];
  logic [7:0] tag_y [RD_LAT];

  logic       cls_skin;
  logic [7:0] cls_x, cls_y;

  logic [ADDR_W-1:0] acc_cnt, cnt_nx;
  logic [7:0] acc_xmn, acc_xmx, acc_ymn, acc_ymx;
  logic [7:0] xmn_nx, xmx_nx, ymn_nx, ymx_nx;

  assign start = (state == ST_IDLE) && (state_nx == ST_SCAN);

  // State register and registered copy of the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      en_z  <= 1'b0;
    end else begin
      state <= state_nx;
      en_z  <= detect_en;
    end
  end

  // Next-state logic and the done pulse.
  always_comb begin
    state_nx    = state;
    detect_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (detect_en && !en_z) state_nx = ST_SCAN;
      end
      ST_SCAN: begin
        if (!detect_en)             state_nx = ST_IDLE;
        else if (rd_addr == A_LAST) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!detect_en)                  state_nx = ST_IDLE;
        else if (drain_cnt == 2'(RD_LAT)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        detect_done = 1'b1;
        state_nx    = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!detect_en) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Drain covers the BRAM latency plus the classifier stage.
  always_ff @(posedge clk) begin
    if (rst || state != ST_DRAIN) drain_cnt <= '0;
    else                          drain_cnt <= drain_cnt + 2'd1;
  end

  // Address and x/y counters advance together, one pixel per cycle.
  always_ff @(posedge clk) begin
    if (rst || state_nx == ST_IDLE) begin
      rd_addr <= '0;
      x_cnt   <= '0;
      y_cnt   <= '0;
    end else if (state == ST_SCAN && state_nx == ST_SCAN) begin
      rd_addr <= rd_addr + 1'b1;
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 8'd1;
      end else begin
        x_cnt <= x_cnt + 8'd1;
      end
    end
  end

  // Tag pipeline matching the BRAM latency; flushed while idle.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_v[i] <= 1'b0;
        tag_x[i] <= '0;
        tag_y[i] <= '0;
      end
    end else begin
      tag_v[0] <= (state == ST_SCAN);
      tag_x[0] <= x_cnt;
      tag_y[0] <= y_cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_x[i] <= tag_x[i-1];
        tag_y[i] <= tag_y[i-1];
      end
    end
  end

  skin_pixel_classifier #(
    .CB_MIN (CB_MIN),
    .CB_MAX (CB_MAX),
    .CR_MIN (CR_MIN),
    .CR_MAX (CR_MAX)
  ) u_cls (
    .clk      (clk),
    .rst      (rst),
    .in_valid (tag_v[RD_LAT-1] && state != ST_IDLE),
    .cb       (rd_data[FD_CB_LSB +: FD_CH_W]),
    .cr       (rd_data[FD_CR_LSB +: FD_CH_W]),
    .in_x     (tag_x[RD_LAT-1]),
    .in_y     (tag_y[RD_LAT-1]),
    .out_skin (cls_skin),
    .out_x    (cls_x),
    .out_y    (cls_y)
  );

  // Accumulator update including the pixel leaving the classifier.
  always_comb begin
    cnt_nx = acc_cnt;
    xmn_nx = acc_xmn;
    xmx_nx = acc_xmx;
    ymn_nx = acc_ymn;
    ymx_nx = acc_ymx;
    if (cls_skin) begin
      cnt_nx = acc_cnt + 1'b1;
      if (cls_x < acc_xmn) xmn_nx = cls_x;
      if (cls_x > acc_xmx) xmx_nx = cls_x;
      if (cls_y < acc_ymn) ymn_nx = cls_y;
      if (cls_y > acc_ymx) ymx_nx = cls_y;
    end
  end

  // Working accumulators, cleared at the start of each scan.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      acc_cnt <= '0;
      acc_xmn <= '1;
      acc_xmx <= '0;
      acc_ymn <= '1;
      acc_ymx <= '0;
    end else begin
      acc_cnt <= cnt_nx;
      acc_xmn <= xmn_nx;
      acc_xmx <= xmx_nx;
      acc_ymn <= ymn_nx;
      acc_ymx <= ymx_nx;
    end
  end

  // Results load on entry to DONE; empty frames report a zero box.
  always_ff @(posedge clk) begin
    if (rst) begin
      face_found <= 1'b0;
      skin_count <= '0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
    end else if (state_nx == ST_DONE) begin
      face_found <= cnt_nx >= ADDR_W'(MIN_COUNT);
      skin_count <= cnt_nx;
      if (cnt_nx == '0) begin
        x_min <= '0;
        x_max <= '0;
        y_min <= '0;
        y_max <= '0;
      end else begin
        x_min <= xmn_nx;
        x_max <= xmx_nx;
        y_min <= ymn_nx;
        y_max <= ymx_nx;
      end
    end
  end

endmodule

// File: tb/tb_skin_region_detector.sv
// Directed bench for skin_region_detector: frame patterns, thresholds,
// done timing, abort, held enable and mid-scan reset.
module tb_skin_region_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic        detect_en;
  logic [14:0] rd_addr;
  logic [19:0] rd_data;
  logic        detect_done;
  logic        face_found;
  logic [14:0] skin_count;
  logic [7:0]  x_min, x_max, y_min, y_max;

  logic [19:0] mem [0:32767];

  int checks   = 0;
  int failures = 0;
  int dc, np, cad;

  localparam int NPIX    = 19200;
  localparam int DONE_AT = NPIX + 1 + 1;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  skin_region_detector dut (
    .clk         (clk),
    .rst         (rst),
    .detect_en   (detect_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .detect_done (detect_done),
    .face_found  (face_found),
    .skin_count  (skin_count),
    .x_min       (x_min),
    .x_max       (x_max),
    .y_min       (y_min),
    .y_max       (y_max)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pix(input int cb, input int cr);
    logic [9:0] b, r;
    b = 10'(cb);
    r = 10'(cr);
    return {r, b};
  endfunction

  // 0 uniform skin, 1 30x30 block, 2 no skin, 3 threshold edges
  task automatic fill(input int mode);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        case (mode)
          0: mem[y*160+x] = pix(400, 600);
          1: mem[y*160+x] = (x >= 40 && x <= 69 && y >= 20 && y <= 49)
                            ? pix(400, 600) : pix(0, 600);
          default: mem[y*160+x] = pix(0, 0);
        endcase
      end
    if (mode == 3) begin
      mem[5*160+10]  = pix(308, 600);
      mem[6*160+20]  = pix(508, 600);
      mem[7*160+30]  = pix(400, 532);
      mem[8*160+40]  = pix(400, 692);
      mem[9*160+50]  = pix(307, 600);
      mem[10*160+60] = pix(400, 693);
      mem[100*160+70] = pix(509, 600);
    end
  endtask

  task automatic check_res(input string t, input int c, input int xa,
                           input int xb, input int ya, input int yb,
                           input int ff);
    check({t, "_cnt"}, 32'(skin_count), c);
    check({t, "_xmin"}, 32'(x_min), xa);
    check({t, "_xmax"}, 32'(x_max), xb);
    check({t, "_ymin"}, 32'(y_min), ya);
    check({t, "_ymax"}, 32'(y_max), yb);
    check({t, "_face"}, 32'(face_found), ff);
  endtask

  task automatic run_scan(input string t, input int hold,
                          output int done_cyc, output int pulses,
                          output int cnt_at_done);
    done_cyc = -1;
    pulses = 0;
    cnt_at_done = -1;
    @(negedge clk) detect_en = 1'b1;
    @(posedge clk); #1;
    check({t, "_addr_c0"}, 32'(rd_addr), 0);
    for (int c = 0; c < 25000; c++) begin
      if (c == 5) check({t, "_addr_c5"}, 32'(rd_addr), 5);
      if (detect_done) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc = c;
          cnt_at_done = int'(skin_count);
        end
      end
      if (done_cyc >= 0 && c >= done_cyc + hold) break;
      @(posedge clk); #1;
    end
    if (done_cyc < 0) check({t, "_timeout"}, 1, 0);
    @(negedge clk) detect_en = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (detect_done) pulses++;
    end
  endtask

  task automatic run_abort();
    int p;
    p = 0;
    @(negedge clk) detect_en = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 6000; c++) begin
      if (rd_addr == 15'd5000) break;
      @(posedge clk); #1;
    end
    check("abort_reach", 32'(rd_addr), 5000);
    @(negedge clk) detect_en = 1'b0;
    @(posedge clk); #1;
    check("abort_addr", 32'(rd_addr), 0);
    repeat (30) begin
      @(posedge clk); #1;
      if (detect_done) p++;
    end
    check("abort_done", p, 0);
  endtask

  initial begin
    rst = 1'b1;
    detect_en = 1'b0;
    fill(2);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_addr", 32'(rd_addr), 0);
    check("rst_done", 32'(detect_done), 0);
    check_res("rst", 0, 0, 0, 0, 0, 0);

    fill(1);
    run_scan("blk", 0, dc, np, cad);
    check("blk_done_cyc", dc, DONE_AT);
    check("blk_pulses", np, 1);
    check("blk_cnt_at_done", cad, 900);
    check_res("blk", 900, 40, 69, 20, 49, 1);

    fill(0);
    run_abort();
    check_res("abort", 900, 40, 69, 20, 49, 1);

    run_scan("uni", 10, dc, np, cad);
    check("uni_done_cyc", dc, DONE_AT);
    check("uni_pulses", np, 1);
    check("uni_cnt_at_done", cad, 19200);
    check_res("uni", 19200, 0, 159, 0, 119, 1);

    fill(2);
    run_scan("none", 0, dc, np, cad);
    check("none_pulses", np, 1);
    check_res("none", 0, 0, 0, 0, 0, 0);

    fill(3);
    run_scan("thr", 0, dc, np, cad);
    check("thr_pulses", np, 1);
    check_res("thr", 4, 10, 40, 5, 8, 0);

    fill(0);
    @(negedge clk) detect_en = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_addr", 32'(rd_addr), 0);
    check("mrst_done", 32'(detect_done), 0);
    check_res("mrst", 0, 0, 0, 0, 0, 0);
    @(negedge clk) begin
      rst = 1'b0;
      detect_en = 1'b0;
    end
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
